// File: rtl/siganfu_fire_controller_if.sv
// siganfu_fire_controller_if: command/status bus between the fire controller and the machine gun
//   master (controller): drives target_locked, is_enemy, fire_command, firing_mode, overheat_sensor;
//                        observes gun_state, gun_fire_pulse, gun_critical
//   slave  (gun):        the mirror image
interface siganfu_fire_controller_if;
  logic       target_locked;
  logic       is_enemy;
  logic       fire_command;
  logic       firing_mode;
  logic       overheat_sensor;
  logic [2:0] gun_state;
  logic       gun_fire_pulse;
  logic       gun_critical;
  modport master (
    output target_locked, is_enemy, fire_command, firing_mode, overheat_sensor,
    input  gun_state, gun_fire_pulse, gun_critical
  );
  modport slave (
    input  target_locked, is_enemy, fire_command, firing_mode, overheat_sensor,
    output gun_state, gun_fire_pulse, gun_critical
  );
endinterface

// File: rtl/siganfu_fire_controller.sv
// siganfu_fire_controller: track qualification, IFF handshake, trigger gating and barrel heat model
//   sysclk, reboot_n (async active-low)            clock / reset
//   track_valid, iff_resp_valid, iff_resp_friend   radar and IFF transponder inputs
//   operator_trigger, operator_auto                operator console
//   gun (master modport)                           commands to / status from the gun
//   iff_req, heat_level, iff_fault, ctrl_state     status outputs
//   Optional: define SIGANFU_AMMO_CONSERVE_EN to force single-shot mode while the gun is critical.
module siganfu_fire_controller #(
  parameter int LOCK_CYCLES   = 4,
  parameter int IFF_TIMEOUT   = 16,
  parameter int HEAT_W        = 8,
  parameter int HEAT_PER_SHOT = 8,
  parameter int HEAT_MAX      = 200,
  parameter int HEAT_RESUME   = 100,
  parameter int COOL_DIV      = 4
) (
  input  logic                  sysclk,
  input  logic                  reboot_n,
  input  logic                  track_valid,
  input  logic                  iff_resp_valid,
  input  logic                  iff_resp_friend,
  input  logic                  operator_trigger,
  input  logic                  operator_auto,
  siganfu_fire_controller_if.master gun,
  output logic                  iff_req,
  output logic [HEAT_W-1:0]     heat_level,
  output logic                  iff_fault,
  output logic [2:0]            ctrl_state
);
  localparam int TW = $clog2(IFF_TIMEOUT + 1);
  localparam int CW = COOL_DIV > 1 ? $clog2(COOL_DIV) : 1;
  localparam logic [3:0]        LOCK_N    = 4'(LOCK_CYCLES);
  localparam logic [TW-1:0]     TMO       = TW'(IFF_TIMEOUT);
  localparam logic [CW-1:0]     COOL_LAST = CW'(COOL_DIV - 1);
  localparam logic [HEAT_W:0]   HEAT_ADD  = (HEAT_W+1)'(HEAT_PER_SHOT);
  localparam logic [HEAT_W-1:0] HMAX      = HEAT_W'(HEAT_MAX);
  localparam logic [HEAT_W-1:0] HRES      = HEAT_W'(HEAT_RESUME);
  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    ACQUIRE     = 3'b001,
    INTERROGATE = 3'b010,
    ENGAGE      = 3'b011,
    HOLD        = 3'b100,
    ABORT       = 3'b101
  } state_t;
  state_t            state_q, state_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d, lock_inc;
  logic [TW-1:0]     tmr_q, tmr_d, tmr_inc;
  logic              locked_q, locked_d;
  logic              enemy_q, enemy_d;
  logic              fire_q, fire_d;
  logic              mode_q, mode_d;
  logic              iff_req_q, iff_req_d;
  logic              fault_q, fault_d;
  logic [HEAT_W-1:0] heat_q, heat_d, heat_sat;
  logic [HEAT_W:0]   heat_sum;
  logic [CW-1:0]     cool_q, cool_d;
  logic              pulse_q, pulse_d;
  logic              ovh_q, ovh_d;
  logic              shot, decay, auto_eff;
`ifdef SIGANFU_AMMO_CONSERVE_EN
  assign auto_eff = operator_auto & ~gun.gun_critical;
`else
  logic unused_crit;
  assign unused_crit = gun.gun_critical;
  assign auto_eff    = operator_auto;
`endif
  // IDLE counts as lock_cnt=0, so the first valid cycle yields 1 and LOCK_CYCLES=1 locks at once
  assign lock_inc = (state_q == IDLE ? 4'd0 : lock_cnt_q) + 4'd1;
  assign tmr_inc  = tmr_q + TW'(1);
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    tmr_d      = tmr_q;
    locked_d   = locked_q;
    enemy_d    = enemy_q;
    fire_d     = fire_q;
    mode_d     = mode_q;
    iff_req_d  = 1'b0;
    fault_d    = fault_q;
    if (gun.gun_state == 3'b101) begin
      state_d    = ABORT;
      lock_cnt_d = 4'd0;
      locked_d   = 1'b0;
      enemy_d    = 1'b0;
      fire_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACQUIRE: begin
          if (!track_valid) begin
            state_d    = IDLE;
            lock_cnt_d = 4'd0;
          end else if (lock_inc >= LOCK_N) begin
            state_d    = INTERROGATE;
            lock_cnt_d = 4'd0;
            locked_d   = 1'b1;
            iff_req_d  = 1'b1;
            tmr_d      = '0;
          end else begin
            state_d    = ACQUIRE;
            lock_cnt_d = lock_inc;
          end
        end
        INTERROGATE: begin
          // a response on the timeout cycle wins over the timeout
          if (!track_valid) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            enemy_d  = 1'b0;
            fire_d   = 1'b0;
          end else if (iff_resp_valid) begin
            state_d = iff_resp_friend ? HOLD : ENGAGE;
            enemy_d = ~iff_resp_friend;
          end else if (tmr_inc >= TMO) begin
            state_d = HOLD;
            enemy_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        ENGAGE: begin
          if (!track_valid) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            enemy_d  = 1'b0;
            fire_d   = 1'b0;
          end else begin
            fire_d = operator_trigger;
            // mode is frozen for the duration of a burst
            mode_d = fire_q ? mode_q : auto_eff;
          end
        end
        HOLD: begin
          fire_d = 1'b0;
          if (!track_valid) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            enemy_d  = 1'b0;
          end
        end
        ABORT: begin
          locked_d = 1'b0;
          enemy_d  = 1'b0;
          fire_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // heat: a shot restarts the cooling interval, so decay needs COOL_DIV shot-free cycles
  assign shot     = gun.gun_fire_pulse & ~pulse_q;
  assign decay    = cool_q == COOL_LAST;
  assign heat_sum = {1'b0, heat_q} + HEAT_ADD;
  assign heat_sat = heat_sum[HEAT_W] ? '1 : heat_sum[HEAT_W-1:0];
  always_comb begin
    pulse_d = gun.gun_fire_pulse;
    heat_d  = shot ? heat_sat : (decay && heat_q != '0) ? heat_q - 1'b1 : heat_q;
    cool_d  = (shot || decay) ? '0 : cool_q + 1'b1;
    // hysteresis evaluated on the new heat so overheat and heat_level move together
    ovh_d   = heat_d >= HMAX ? 1'b1 : heat_d <= HRES ? 1'b0 : ovh_q;
  end
  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      tmr_q      <= '0;
      locked_q   <= 1'b0;
      enemy_q    <= 1'b0;
      fire_q     <= 1'b0;
      mode_q     <= 1'b0;
      iff_req_q  <= 1'b0;
      fault_q    <= 1'b0;
      heat_q     <= '0;
      cool_q     <= '0;
      pulse_q    <= 1'b0;
      ovh_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      tmr_q      <= tmr_d;
      locked_q   <= locked_d;
      enemy_q    <= enemy_d;
      fire_q     <= fire_d;
      mode_q     <= mode_d;
      iff_req_q  <= iff_req_d;
      fault_q    <= fault_d;
      heat_q     <= heat_d;
      cool_q     <= cool_d;
      pulse_q    <= pulse_d;
      ovh_q      <= ovh_d;
    end
  end
  assign gun.target_locked   = locked_q;
  assign gun.is_enemy        = enemy_q;
  assign gun.fire_command    = fire_q;
  assign gun.firing_mode     = mode_q;
  assign gun.overheat_sensor = ovh_q;
  assign iff_req             = iff_req_q;
  assign heat_level          = heat_q;
  assign iff_fault           = fault_q;
  assign ctrl_state          = state_q;
endmodule

// File: tb/tb_siganfu_fire_controller.sv
// tb_siganfu_fire_controller: directed scoreboard bench for siganfu_fire_controller
module tb_siganfu_fire_controller;
  localparam int ST = 0, REQ = 1, LCK = 2, ENM = 3, FIR = 4, MOD = 5, OVH = 6, HT = 7, FLT = 8;
  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;
  logic sysclk = 1'b0;
  logic reboot_n, track_valid, iff_resp_valid, iff_resp_friend, operator_trigger, operator_auto;
  logic       iff_req, iff_fault;
  logic [7:0] heat_level;
  logic [2:0] ctrl_state;
  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  siganfu_fire_controller_if bus ();
  siganfu_fire_controller dut (
    .sysclk           (sysclk),
    .reboot_n         (reboot_n),
    .track_valid      (track_valid),
    .iff_resp_valid   (iff_resp_valid),
    .iff_resp_friend  (iff_resp_friend),
    .operator_trigger (operator_trigger),
    .operator_auto    (operator_auto),
    .gun              (bus.master),
    .iff_req          (iff_req),
    .heat_level       (heat_level),
    .iff_fault        (iff_fault),
    .ctrl_state       (ctrl_state)
  );
  always #5 sysclk = ~sysclk;
  function automatic logic [7:0] obs(int s);
    case (s)
      ST:      return {5'd0, ctrl_state};
      REQ:     return {7'd0, iff_req};
      LCK:     return {7'd0, bus.target_locked};
      ENM:     return {7'd0, bus.is_enemy};
      FIR:     return {7'd0, bus.fire_command};
      MOD:     return {7'd0, bus.firing_mode};
      OVH:     return {7'd0, bus.overheat_sensor};
      HT:      return heat_level;
      default: return {7'd0, iff_fault};
    endcase
  endfunction
  task automatic ex(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask
  task automatic ex_zero(input string tag);
    for (int s = 0; s <= FLT; s++) ex(tag, s, 8'd0);
  endtask
  task automatic drain();
    exp_t e;
    logic [7:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $display("FAIL %s sel=%0d observed=%0d expected=%0d", e.tag, e.sel, o, e.exp);
        $error("miscompare on %s", e.tag);
      end
    end
  endtask
  task automatic step();
    @(posedge sysclk);
    #1;
    drain();
  endtask
  task automatic lock(input string tag);
    track_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex({tag, "_acq"}, ST, 8'd1);
      ex({tag, "_noreq"}, REQ, 8'd0);
      step();
    end
    ex({tag, "_int"}, ST, 8'd2);
    ex({tag, "_locked"}, LCK, 8'd1);
    ex({tag, "_req"}, REQ, 8'd1);
    step();
  endtask
  initial begin
    logic [7:0] h;
    logic       ov;
    reboot_n = 1'b0; track_valid = 1'b0; iff_resp_valid = 1'b0; iff_resp_friend = 1'b0;
    operator_trigger = 1'b0; operator_auto = 1'b0;
    bus.gun_state = 3'd0; bus.gun_fire_pulse = 1'b0; bus.gun_critical = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    ex_zero("reset");
    drain();
    reboot_n = 1'b1;
    // short track: no lock
    track_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex("short_acq", ST, 8'd1);
      ex("short_noreq", REQ, 8'd0);
      step();
    end
    track_valid = 1'b0;
    ex("short_idle", ST, 8'd0);
    ex("short_noreq2", REQ, 8'd0);
    ex("short_nolock", LCK, 8'd0);
    step();
    // lock, response exactly on the timeout cycle
    lock("lk1");
    for (int i = 0; i < 15; i++) begin
      ex("wait_int", ST, 8'd2);
      ex("req_single", REQ, 8'd0);
      step();
    end
    iff_resp_valid = 1'b1; iff_resp_friend = 1'b0;
    ex("resp_tmo_engage", ST, 8'd3);
    ex("resp_enemy", ENM, 8'd1);
    ex("resp_tmo_nofault", FLT, 8'd0);
    step();
    iff_resp_valid = 1'b0;
    // trigger and mode lock during a burst
    operator_trigger = 1'b1;
    ex("fire_on", FIR, 8'd1);
    ex("mode_single", MOD, 8'd0);
    step();
    operator_auto = 1'b1;
    ex("burst_fire", FIR, 8'd1);
    ex("burst_mode_hold", MOD, 8'd0);
    step();
    ex("burst_mode_hold2", MOD, 8'd0);
    step();
    operator_trigger = 1'b0;
    ex("release_fire", FIR, 8'd0);
    ex("release_mode_hold", MOD, 8'd0);
    step();
    ex("mode_auto", MOD, 8'd1);
    ex("engage_stay", ST, 8'd3);
    step();
    bus.gun_critical = 1'b1;
`ifdef SIGANFU_AMMO_CONSERVE_EN
    ex("crit_mode", MOD, 8'd0);
`else
    ex("crit_mode", MOD, 8'd1);
`endif
    step();
    bus.gun_critical = 1'b0;
    // track loss in ENGAGE with trigger held
    operator_trigger = 1'b1; track_valid = 1'b0;
    ex("loss_idle", ST, 8'd0);
    ex("loss_lock", LCK, 8'd0);
    ex("loss_enemy", ENM, 8'd0);
    ex("loss_fire", FIR, 8'd0);
    step();
    // IFF timeout -> HOLD, trigger held throughout
    lock("lk2");
    for (int i = 0; i < 15; i++) begin
      ex("tmo_wait", ST, 8'd2);
      ex("tmo_nofault", FLT, 8'd0);
      step();
    end
    ex("tmo_hold", ST, 8'd4);
    ex("tmo_fault", FLT, 8'd1);
    ex("tmo_friend", ENM, 8'd0);
    ex("tmo_nofire", FIR, 8'd0);
    ex("tmo_locked", LCK, 8'd1);
    step();
    iff_resp_valid = 1'b1; iff_resp_friend = 1'b0;
    ex("hold_ign_resp", ST, 8'd4);
    ex("hold_ign_enemy", ENM, 8'd0);
    ex("hold_nofire", FIR, 8'd0);
    step();
    iff_resp_valid = 1'b0; track_valid = 1'b0;
    ex("hold_drop", ST, 8'd0);
    ex("fault_sticky", FLT, 8'd1);
    ex("hold_drop_lock", LCK, 8'd0);
    step();
    operator_trigger = 1'b0;
    // ABORT beats track loss
    lock("lk3");
    iff_resp_valid = 1'b1; iff_resp_friend = 1'b0;
    ex("ab_engage", ST, 8'd3);
    step();
    iff_resp_valid = 1'b0; operator_trigger = 1'b1;
    ex("ab_fire", FIR, 8'd1);
    step();
    bus.gun_state = 3'b101; track_valid = 1'b0;
    ex("abort_state", ST, 8'd5);
    ex("abort_lock", LCK, 8'd0);
    ex("abort_enemy", ENM, 8'd0);
    ex("abort_fire", FIR, 8'd0);
    step();
    bus.gun_state = 3'd0; track_valid = 1'b1; iff_resp_valid = 1'b1;
    ex("abort_sticky", ST, 8'd5);
    ex("abort_fire2", FIR, 8'd0);
    ex("abort_enemy2", ENM, 8'd0);
    ex("abort_noreq", REQ, 8'd0);
    step();
    iff_resp_valid = 1'b0; operator_trigger = 1'b0;
    ex("abort_sticky2", ST, 8'd5);
    step();
    // heat: 32 back-to-back shots
    h = 8'd0;
    ov = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      bus.gun_fire_pulse = 1'b1;
      h = (h > 8'd247) ? 8'd255 : h + 8'd8;
      ov = (h >= 8'd200) ? 1'b1 : (h <= 8'd100) ? 1'b0 : ov;
      ex("heat_add", HT, h);
      ex("heat_ovh", OVH, {7'd0, ov});
      step();
      bus.gun_fire_pulse = 1'b0;
      ex("heat_gap", HT, h);
      step();
    end
    ex("heat_cool1", HT, 8'd255);
    step();
    ex("heat_cool2", HT, 8'd255);
    step();
    ex("heat_decay", HT, 8'd254);
    ex("heat_ovh_hold", OVH, 8'd1);
    step();
    for (int i = 0; i < 1000 && bus.overheat_sensor; i++) step();
    ex("ovh_clear", OVH, 8'd0);
    ex("ovh_clear_heat", HT, 8'd100);
    drain();
    // asynchronous reset mid-operation
    #3;
    reboot_n = 1'b0;
    #1;
    ex_zero("async_rst");
    drain();
    @(posedge sysclk);
    #1;
    reboot_n = 1'b1; track_valid = 1'b0;
    ex_zero("post_rst");
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
